// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed when the request is accepted and committed after a fixed busy period.
module muldiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [63:0] prod_s, prod_u;
  logic        signed_div;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, q_res, r_res;

  assign prod_u = {32'd0, a} * {32'd0, b};
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  // Divide on magnitudes so the most-negative / -1 case wraps cleanly to 0x80000000.
  assign signed_div = (op[0] == 1'b0);
  assign a_mag = (signed_div && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (signed_div && b[31]) ? (~b + 32'd1) : b;
  assign b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;
  assign q_res = (signed_div && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
  assign r_res = (signed_div && a[31]) ? (~r_mag + 32'd1) : r_mag;

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: only mult/div requests leave IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && (op[2] == 1'b0)) state_d = S_BUSY;
        else                          state_d = S_IDLE;
      end
      S_BUSY: begin
        if (cnt_q <= 4'd1) state_d = S_IDLE;
        else               state_d = S_BUSY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output logic; requests arriving while BUSY are dropped.
  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    busy_d    = (state_d == S_BUSY);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'd0: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_CNT;
            end
            3'd1: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_CNT;
            end
            3'd2, 3'd3: begin
              pend_hi_d = r_res;
              pend_lo_d = q_res;
              pend_wr_d = (b != 32'd0);
              cnt_d     = DIV_CNT;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: cnt_d = cnt_q;
          endcase
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d  = 4'd0;
          done_d = 1'b1;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      default: cnt_d = 4'd0;
    endcase
  end

endmodule
